monitor_alarme_usina: RTL and testbench

- Sequential successor to the control-room alarm (sala de controle).
- Samples three reactor sensors: temperature, pressure and radiation.
- Each channel must stay over its threshold for a programmable number of consecutive cycles before an alarm is raised. An alarm stays latched until the operator acknowledges it, then clears with hysteresis.
- Sits between the sensor interface and the control-room sounder/lamp panel; also exports per-channel status and a saturating alarm-event counter.

---
 rtl/monitor_alarme_usina_pkg.sv | 15 +
 rtl/monitor_alarme_usina_if.sv | 26 ++
 rtl/monitor_alarme_usina_canal.sv | 92 +++++++++
 rtl/monitor_alarme_usina.sv | 60 ++++++
 tb/tb_monitor_alarme_usina.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/monitor_alarme_usina_pkg.sv
// Shared types for the plant alarm monitor: per-channel state encoding and channel indices.
package monitor_alarme_pkg;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        PENDENTE    = 2'd1,
        ALARME      = 2'd2,
        RECONHECIDO = 2'd3
    } estado_t;

    localparam int CH_TEMP = 0;
    localparam int CH_PRES = 1;
    localparam int CH_RAD  = 2;

endpackage

// File: rtl/monitor_alarme_usina_if.sv
// Sensor/operator inputs and sounder/lamp/status outputs of the alarm monitor.
interface monitor_alarme_usina_if #(
    parameter int TEMP_W = 8,
    parameter int PRES_W = 4,
    parameter int RAD_W  = 12,
    parameter int EVT_W  = 8
);
    logic [TEMP_W-1:0] temp;
    logic [PRES_W-1:0] pressao;
    logic [RAD_W-1:0]  radiacao;
    logic              reconhecer;
    logic              alarme_sonoro;
    logic              alarme_visual;
    logic [5:0]        estado_canal;
    logic [EVT_W-1:0]  eventos;

    modport master (
        output temp, pressao, radiacao, reconhecer,
        input  alarme_sonoro, alarme_visual, estado_canal, eventos
    );

    modport slave (
        input  temp, pressao, radiacao, reconhecer,
        output alarme_sonoro, alarme_visual, estado_canal, eventos
    );
endinterface

// File: rtl/monitor_alarme_usina_canal.sv
// One sensor channel: registered sample, threshold/hysteresis compare, persistence counter
// and latched alarm FSM. entrada pulses combinationally on the edge that enters ALARME.
//
//   state       | meaning
//   NORMAL      | below threshold, no alarm
//   PENDENTE    | over threshold, counting consecutive samples
//   ALARME      | latched alarm, sounder on, waiting for acknowledge
//   RECONHECIDO | acknowledged, lamp on until sample drops below LIM-HYST
module canal_alarme
    import monitor_alarme_pkg::*;
#(
    parameter int W       = 8,
    parameter int LIM     = 40,
    parameter int HYST    = 5,
    parameter int PERSIST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] leitura,
    input  logic         reconhecer,
    output estado_t      estado,
    output logic         entrada
);

    if (HYST > LIM || LIM >= (1 << W) || PERSIST < 1 || PERSIST > 255) begin : gParamInvalido
        $error("canal_alarme: invalid LIM/HYST/PERSIST for width W");
    end

    localparam logic [W-1:0] LIM_V   = W'(LIM);
    localparam logic [W-1:0] CLR_V   = W'(LIM - HYST);
    localparam logic [7:0]   CNT_FIM = 8'(PERSIST - 1);

    logic [W-1:0] amostra;
    logic [7:0]   cnt, cntNext;
    estado_t      estadoNext;
    logic         over, clear;

    assign over  = amostra >= LIM_V;
    assign clear = amostra < CLR_V;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amostra <= '0;
            cnt     <= '0;
            estado  <= NORMAL;
        end else begin
            amostra <= leitura;
            cnt     <= cntNext;
            estado  <= estadoNext;
        end
    end

    always_comb begin
        estadoNext = estado;
        cntNext    = cnt;
        entrada    = 1'b0;
        case (estado)
            NORMAL: begin
                if (over) begin
                    if (PERSIST == 1) begin
                        estadoNext = ALARME;
                        entrada    = 1'b1;
                    end else begin
                        estadoNext = PENDENTE;
                        cntNext    = 8'd1;
                    end
                end
            end
            PENDENTE: begin
                if (!over) begin
                    estadoNext = NORMAL;
                    cntNext    = '0;
                end else if (cnt == CNT_FIM) begin
                    estadoNext = ALARME;
                    cntNext    = '0;
                    entrada    = 1'b1;
                end else begin
                    cntNext = cnt + 8'd1;
                end
            end
            ALARME: begin
                if (reconhecer) estadoNext = clear ? NORMAL : RECONHECIDO;
            end
            RECONHECIDO: begin
                // a new over here must not re-sound until the channel has been NORMAL
                if (clear) estadoNext = NORMAL;
            end
            default: estadoNext = NORMAL;
        endcase
    end

endmodule

// File: rtl/monitor_alarme_usina.sv
// Plant alarm monitor top: three independent channels, sounder/lamp decode and a
// saturating count of ALARME entries.
module monitor_alarme_usina
    import monitor_alarme_pkg::*;
#(
    parameter int TEMP_W    = 8,
    parameter int PRES_W    = 4,
    parameter int RAD_W     = 12,
    parameter int TEMP_LIM  = 40,
    parameter int PRES_LIM  = 7,
    parameter int RAD_LIM   = 1000,
    parameter int TEMP_HYST = 5,
    parameter int PRES_HYST = 1,
    parameter int RAD_HYST  = 100,
    parameter int PERSIST   = 4,
    parameter int EVT_W     = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    monitor_alarme_usina_if.slave bus
);

    localparam logic [EVT_W:0] EVT_MAX = {1'b0, {EVT_W{1'b1}}};

    estado_t        estados [3];
    logic [2:0]     entradas;
    logic [1:0]     nEntradas;
    logic [EVT_W-1:0] eventos;
    logic [EVT_W:0] soma;

    canal_alarme #(.W(TEMP_W), .LIM(TEMP_LIM), .HYST(TEMP_HYST), .PERSIST(PERSIST)) uTemp (
        .clk(clk), .rst_n(rst_n), .leitura(bus.temp), .reconhecer(bus.reconhecer),
        .estado(estados[CH_TEMP]), .entrada(entradas[CH_TEMP])
    );

    canal_alarme #(.W(PRES_W), .LIM(PRES_LIM), .HYST(PRES_HYST), .PERSIST(PERSIST)) uPres (
        .clk(clk), .rst_n(rst_n), .leitura(bus.pressao), .reconhecer(bus.reconhecer),
        .estado(estados[CH_PRES]), .entrada(entradas[CH_PRES])
    );

    canal_alarme #(.W(RAD_W), .LIM(RAD_LIM), .HYST(RAD_HYST), .PERSIST(PERSIST)) uRad (
        .clk(clk), .rst_n(rst_n), .leitura(bus.radiacao), .reconhecer(bus.reconhecer),
        .estado(estados[CH_RAD]), .entrada(entradas[CH_RAD])
    );

    assign nEntradas = 2'(entradas[0]) + 2'(entradas[1]) + 2'(entradas[2]);
    assign soma      = {1'b0, eventos} + (EVT_W+1)'(nEntradas);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) eventos <= '0;
        else        eventos <= (soma > EVT_MAX) ? EVT_MAX[EVT_W-1:0] : soma[EVT_W-1:0];
    end

    assign bus.alarme_sonoro = (estados[0] == ALARME) || (estados[1] == ALARME) ||
                               (estados[2] == ALARME);
    assign bus.alarme_visual = estados[0][1] || estados[1][1] || estados[2][1];
    assign bus.estado_canal  = {estados[CH_RAD], estados[CH_PRES], estados[CH_TEMP]};
    assign bus.eventos       = eventos;

endmodule

// File: tb/tb_monitor_alarme_usina.sv
// Self-checking bench: directed scenarios plus random near-threshold stimulus,
// compared cycle by cycle against a run-length reference model.
module tb_monitor_alarme_usina;

    localparam int TEMP_W  = 8;
    localparam int PRES_W  = 4;
    localparam int RAD_W   = 12;
    localparam int EVT_W   = 8;
    localparam int PERSIST = 4;
    localparam int EVT_SAT = (1 << EVT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    monitor_alarme_usina_if #(.TEMP_W(TEMP_W), .PRES_W(PRES_W), .RAD_W(RAD_W), .EVT_W(EVT_W)) bus ();

    monitor_alarme_usina #(.PERSIST(PERSIST), .EVT_W(EVT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int nChk = 0;
    int nOk  = 0;

    task automatic verifica(input string tag, input int obs, input int esp);
        nChk++;
        if (obs == esp) nOk++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, esp);
    endtask

    // Reference model: per channel a mode (idle / alarm / acknowledged) plus the length
    // of the current run of consecutive over-threshold samples.
    int limites [3] = '{40, 7, 1000};
    int histers [3] = '{5, 1, 100};
    int mModo [3];   // 0 idle, 2 alarm, 3 acknowledged
    int mRun  [3];
    int mAmostra [3];
    int mEvt;

    function automatic int estadoEsperado(input int ch);
        if (mModo[ch] == 0) return (mRun[ch] > 0) ? 1 : 0;
        return mModo[ch];
    endfunction

    task automatic modeloReset();
        for (int ch = 0; ch < 3; ch++) begin
            mModo[ch] = 0; mRun[ch] = 0; mAmostra[ch] = 0;
        end
        mEvt = 0;
    endtask

    task automatic modeloPasso(input int t, input int p, input int r, input bit ack);
        int novos[3];
        int entradas;
        bit acima, limpo;
        novos = '{t, p, r};
        entradas = 0;
        for (int ch = 0; ch < 3; ch++) begin
            acima = mAmostra[ch] >= limites[ch];
            limpo = mAmostra[ch] < limites[ch] - histers[ch];
            if (mModo[ch] == 0) begin
                if (acima) begin
                    mRun[ch]++;
                    if (mRun[ch] >= PERSIST) begin
                        mModo[ch] = 2; mRun[ch] = 0; entradas++;
                    end
                end else mRun[ch] = 0;
            end else if (mModo[ch] == 2) begin
                if (ack) mModo[ch] = limpo ? 0 : 3;
            end else if (limpo) mModo[ch] = 0;
            mAmostra[ch] = novos[ch];
        end
        mEvt = (mEvt + entradas > EVT_SAT) ? EVT_SAT : mEvt + entradas;
    endtask

    task automatic comparaTudo(input string tag);
        int e0, e1, e2;
        e0 = estadoEsperado(0); e1 = estadoEsperado(1); e2 = estadoEsperado(2);
        verifica({tag, "_estado"}, int'(bus.estado_canal), e0 | (e1 << 2) | (e2 << 4));
        verifica({tag, "_sonoro"}, int'(bus.alarme_sonoro), int'(e0 == 2 || e1 == 2 || e2 == 2));
        verifica({tag, "_visual"}, int'(bus.alarme_visual), int'(e0 >= 2 || e1 >= 2 || e2 >= 2));
        verifica({tag, "_eventos"}, int'(bus.eventos), mEvt);
    endtask

    task automatic passo(input string tag, input int t, input int p, input int r, input bit ack);
        bus.temp       = TEMP_W'(t);
        bus.pressao    = PRES_W'(p);
        bus.radiacao   = RAD_W'(r);
        bus.reconhecer = ack;
        modeloPasso(t, p, r, ack);
        @(posedge clk);
        #1;
        comparaTudo(tag);
    endtask

    task automatic aplicaReset();
        rst_n = 1'b0;
        bus.temp = '0; bus.pressao = '0; bus.radiacao = '0; bus.reconhecer = 1'b0;
        modeloReset();
        repeat (2) @(posedge clk);
        #1;
        comparaTudo("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int evtAntes;
    int tR, pR, rR, holdT, holdP, holdR;

    initial begin
        aplicaReset();

        // temperature at threshold: alarm on the fifth edge
        repeat (4) passo("temp_pend", 40, 0, 0, 1'b0);
        verifica("temp_antes_edge5", int'(bus.alarme_sonoro), 0);
        passo("temp_edge5", 40, 0, 0, 1'b0);
        verifica("temp_sonoro_edge5", int'(bus.alarme_sonoro), 1);
        verifica("temp_eventos_1", int'(bus.eventos), 1);
        repeat (2) passo("temp_ack", 0, 0, 0, 1'b1);
        verifica("temp_limpo", int'(bus.estado_canal[1:0]), 0);

        // three over samples then 39: never alarms
        repeat (3) passo("temp_curto", 40, 0, 0, 1'b0);
        repeat (3) passo("temp_curto", 39, 0, 0, 1'b0);
        verifica("temp_curto_normal", int'(bus.estado_canal[1:0]), 0);
        verifica("temp_curto_evt", int'(bus.eventos), 1);

        // radiation: alarm, hysteresis band, acknowledge, clear
        repeat (6) passo("rad_sobe", 0, 0, 1000, 1'b0);
        repeat (2) passo("rad_banda", 0, 0, 950, 1'b0);
        passo("rad_ack", 0, 0, 950, 1'b1);
        verifica("rad_reconh_sonoro", int'(bus.alarme_sonoro), 0);
        verifica("rad_reconh_visual", int'(bus.alarme_visual), 1);
        verifica("rad_reconh_estado", int'(bus.estado_canal[5:4]), 3);
        repeat (2) passo("rad_limpa", 0, 0, 899, 1'b0);
        verifica("rad_limpo_visual", int'(bus.alarme_visual), 0);

        // pressure: alarm stays latched until ack, then straight to NORMAL
        repeat (6) passo("pres_sobe", 0, 7, 0, 1'b0);
        repeat (3) passo("pres_cai", 0, 5, 0, 1'b0);
        verifica("pres_latched", int'(bus.estado_canal[3:2]), 2);
        passo("pres_ack", 0, 5, 0, 1'b1);
        verifica("pres_normal", int'(bus.estado_canal[3:2]), 0);

        // all three channels enter ALARME on the same edge
        passo("trio_prep", 0, 0, 0, 1'b0);
        evtAntes = int'(bus.eventos);
        repeat (5) passo("trio", 50, 9, 1500, 1'b0);
        verifica("trio_estado", int'(bus.estado_canal), 6'b101010);
        verifica("trio_delta", int'(bus.eventos) - evtAntes, 3);
        repeat (2) passo("trio_ack", 0, 0, 0, 1'b1);

        // async reset in the middle of a cycle drops everything at once
        repeat (6) passo("mid_sobe", 60, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        verifica("mid_rst_estado", int'(bus.estado_canal), 0);
        verifica("mid_rst_sonoro", int'(bus.alarme_sonoro), 0);
        verifica("mid_rst_eventos", int'(bus.eventos), 0);
        aplicaReset();

        // random near-threshold stimulus with held values so persistence can complete
        holdT = 0; holdP = 0; holdR = 0; tR = 0; pR = 0; rR = 0;
        for (int i = 0; i < 800; i++) begin
            if (holdT == 0) begin tR = $urandom_range(30, 50);  holdT = $urandom_range(1, 7); end
            if (holdP == 0) begin pR = $urandom_range(4, 9);    holdP = $urandom_range(1, 7); end
            if (holdR == 0) begin rR = $urandom_range(850, 1100); holdR = $urandom_range(1, 7); end
            holdT--; holdP--; holdR--;
            passo("rand", tR, pR, rR, ($urandom_range(0, 3) == 0));
        end
        repeat (3) passo("rand_fim", 0, 0, 0, 1'b1);

        // repeated alarm/ack/clear cycles drive eventos into saturation
        for (int k = 0; k < 270; k++) begin
            repeat (5) passo("sat_sobe", 45, 0, 0, 1'b0);
            repeat (2) passo("sat_ack", 0, 0, 0, 1'b1);
        end
        verifica("sat_eventos", int'(bus.eventos), 255);

        $display("%0d/%0d checks passed", nOk, nChk);
        $finish;
    end

endmodule
